// File: rtl/bconv_window_sequencer_if.sv
// Image-row read port and output-pixel port of the binary 3x3 window sequencer.
// The master side is the sequencer; the slave side is memory plus consumer.
interface bconv_window_sequencer_if #(
    parameter int IMG_W = 28,
    parameter int THR_W = 4
);
    logic             start;
    logic [8:0]       kernel_i;
    logic [THR_W-1:0] thresh_i;
    logic             rd_en;
    logic [4:0]       rd_row;
    logic [IMG_W-1:0] rd_data;
    logic             o_valid;
    logic             o_ready;
    logic [4:0]       o_row;
    logic [4:0]       o_col;
    logic             o_bit;
    logic [THR_W-1:0] o_popcnt;
    logic             busy;
    logic             done;

    modport master (
        input  start, kernel_i, thresh_i, rd_data, o_ready,
        output rd_en, rd_row, o_valid, o_row, o_col,
        output o_bit, o_popcnt, busy, done
    );

    modport slave (
        output start, kernel_i, thresh_i, rd_data, o_ready,
        input  rd_en, rd_row, o_valid, o_row, o_col,
        input  o_bit, o_popcnt, busy, done
    );
endinterface

// File: rtl/bconv_window_sequencer.sv
// Binary 3x3 convolution sequencer: fills a 3-row line buffer from row memory
// and sweeps the window, emitting XNOR-popcount thresholded pixels.
module bconv_window_sequencer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int THR_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    bconv_window_sequencer_if.master  bus
);
    localparam logic [4:0] LAST_C = 5'(IMG_W - 3);
    localparam logic [4:0] LAST_R = 5'(IMG_H - 3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_SWEEP,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [8:0]       r_kernel;
    logic [THR_W-1:0] r_thresh;
    logic [IMG_W-1:0] r_buf0;
    logic [IMG_W-1:0] r_buf1;
    logic [IMG_W-1:0] r_buf2;
    logic [4:0]       r_orow;
    logic [4:0]       r_col;
    logic [4:0]       r_rd_row;
    logic [1:0]       r_need;
    logic [1:0]       r_issued;
    logic             r_cap;

    logic             w_fill;
    logic             w_sweep;
    logic             w_rd_en;
    logic             w_fire;
    logic             w_last_col;
    logic [IMG_W-1:0] w_sh0;
    logic [IMG_W-1:0] w_sh1;
    logic [IMG_W-1:0] w_sh2;
    logic [8:0]       w_win;
    logic [8:0]       w_match;
    logic [THR_W-1:0] w_pc;

    assign w_fill     = (r_state == S_FILL);
    assign w_sweep    = (r_state == S_SWEEP);
    assign w_rd_en    = w_fill && (r_issued != r_need);
    assign w_fire     = w_sweep && bus.o_ready;
    assign w_last_col = (r_col == LAST_C);

    // Window bit 3*kr+kc comes from buffer row kr at column col+kc.
    assign w_sh0   = r_buf0 >> r_col;
    assign w_sh1   = r_buf1 >> r_col;
    assign w_sh2   = r_buf2 >> r_col;
    assign w_win   = {w_sh2[2:0], w_sh1[2:0], w_sh0[2:0]};
    assign w_match = ~(w_win ^ r_kernel);

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < 9; i++) begin
            w_pc = w_pc + THR_W'(w_match[i]);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_FILL;
            end
            S_FILL: begin
                if (r_cap && !w_rd_en) w_next = S_SWEEP;
            end
            S_SWEEP: begin
                if (w_fire && w_last_col) begin
                    w_next = (r_orow == LAST_R) ? S_DONE : S_FILL;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kernel <= '0;
            r_thresh <= '0;
            r_orow   <= '0;
            r_col    <= '0;
            r_rd_row <= '0;
            r_need   <= '0;
            r_issued <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_kernel <= bus.kernel_i;
                        r_thresh <= bus.thresh_i;
                        r_orow   <= '0;
                        r_col    <= '0;
                        r_rd_row <= '0;
                        r_need   <= 2'd3;
                        r_issued <= '0;
                    end
                end
                S_FILL: begin
                    if (w_rd_en) begin
                        r_rd_row <= r_rd_row + 5'd1;
                        r_issued <= r_issued + 2'd1;
                    end
                    if (r_cap && !w_rd_en) r_col <= '0;
                end
                S_SWEEP: begin
                    if (w_fire) begin
                        if (w_last_col) begin
                            r_col <= '0;
                            if (r_orow != LAST_R) begin
                                r_orow   <= r_orow + 5'd1;
                                r_rd_row <= r_orow + 5'd3;
                                r_need   <= 2'd1;
                                r_issued <= '0;
                            end
                        end else begin
                            r_col <= r_col + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data returns one cycle after its strobe and shifts in as the new bottom row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap  <= 1'b0;
            r_buf0 <= '0;
            r_buf1 <= '0;
            r_buf2 <= '0;
        end else begin
            r_cap <= w_rd_en;
            if (r_cap) begin
                r_buf0 <= r_buf1;
                r_buf1 <= r_buf2;
                r_buf2 <= bus.rd_data;
            end
        end
    end

    assign bus.rd_en    = w_rd_en;
    assign bus.rd_row   = w_rd_en ? r_rd_row : 5'd0;
    assign bus.o_valid  = w_sweep;
    assign bus.o_row    = w_sweep ? r_orow : 5'd0;
    assign bus.o_col    = w_sweep ? r_col : 5'd0;
    assign bus.o_popcnt = w_sweep ? w_pc : '0;
    assign bus.o_bit    = w_sweep && (w_pc >= r_thresh);
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
endmodule

// File: tb/tb_bconv_window_sequencer.sv
// Table-driven scoreboard bench for bconv_window_sequencer.
// Reference pixels are derived straight from the image memory and kernel.
module tb_bconv_window_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bconv_window_sequencer_if bus ();

    bconv_window_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] c;
        logic       b;
        logic [3:0] pc;
    } pix_t;

    typedef struct {
        int         pat;
        logic [8:0] k;
        logic [3:0] th;
        bit         rnd;
        bit         repulse;
        int         exp_done;
        int         exp_reads;
        int         exp_pix;
    } tcase_t;

    pix_t        exp_q[$];
    logic [27:0] mem[28];
    tcase_t      tv[8];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_reads = 0;
    int          n_done = 0;
    int          n_pix = 0;
    int          exp_rd = 0;
    bit          rdy_rand = 1'b0;
    bit          have_hold = 1'b0;
    pix_t        hold;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pix_t model(int r, int c, logic [8:0] k,
                                   logic [3:0] th);
        pix_t p;
        int   pc = 0;
        for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
                if (mem[r+kr][c+kc] == k[3*kr+kc]) pc++;
            end
        end
        p.r  = 5'(r);
        p.c  = 5'(c);
        p.b  = (pc >= int'(th));
        p.pc = 4'(pc);
        return p;
    endfunction

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_row];
    end

    always @(posedge clk) begin
        #1;
        bus.o_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        pix_t cur;
        if (!rst_n) begin
            have_hold = 1'b0;
        end else begin
            if (!bus.busy) exp_rd = 0;
            if (bus.rd_en) begin
                n_reads++;
                chk("rd_row", 32'(bus.rd_row), 32'(exp_rd));
                chk("rd_while_valid", 32'(bus.o_valid), 0);
                exp_rd++;
            end
            if (bus.done) n_done++;
            if (bus.o_valid) begin
                cur = {bus.o_row, bus.o_col, bus.o_bit, bus.o_popcnt};
                if (have_hold) chk("stall_hold", 32'(cur), 32'(hold));
                if (bus.o_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_pixel", 32'(cur), 32'hFFFF_FFFF);
                    end else begin
                        chk("pixel", 32'(cur), 32'(exp_q.pop_front()));
                    end
                    have_hold = 1'b0;
                    n_pix++;
                end else begin
                    hold = cur;
                    have_hold = 1'b1;
                end
            end else if (have_hold) begin
                chk("stall_drop", 32'(bus.o_valid), 1);
                have_hold = 1'b0;
            end
        end
    end

    task automatic prep(input tcase_t t);
        for (int r = 0; r < 28; r++) begin
            unique case (t.pat)
                0: mem[r] = 28'hAAAAAAA;
                1: mem[r] = 28'h0;
                default: mem[r] = 28'($urandom());
            endcase
        end
        exp_q.delete();
        for (int r = 0; r < 26; r++) begin
            for (int c = 0; c < 26; c++) begin
                exp_q.push_back(model(r, c, t.k, t.th));
            end
        end
        rdy_rand     = t.rnd;
        bus.kernel_i = t.k;
        bus.thresh_i = t.th;
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.kernel_i = ~t.k;
        bus.thresh_i = t.th + 4'd3;
    endtask

    task automatic run_frame(input tcase_t t);
        int rb;
        int db;
        int pb;
        int cyc = 0;
        rb = n_reads;
        db = n_done;
        pb = n_pix;
        prep(t);
        do begin
            @(negedge clk);
            cyc++;
            if (t.repulse && cyc == 300) begin
                bus.start    = 1'b1;
                bus.kernel_i = ~t.k;
            end
            if (t.repulse && cyc == 301) bus.start = 1'b0;
        end while (!bus.done && cyc < 4000);
        chk("done_seen", 32'(bus.done), 1);
        if (t.exp_done != 0) chk("done_cycle", 32'(cyc), 32'(t.exp_done));
        repeat (6) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("reads", 32'(n_reads - rb), 32'(t.exp_reads));
        chk("done_pulses", 32'(n_done - db), 1);
        chk("pixels", 32'(n_pix - pb), 32'(t.exp_pix));
        chk("queue_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        int wait_c;
        bus.start    = 1'b0;
        bus.kernel_i = '0;
        bus.thresh_i = '0;
        bus.o_ready  = 1'b0;
        bus.rd_data  = '0;
        tv[0] = '{0, 9'b101010101, 4'd5,  1'b0, 1'b0, 731, 28, 676};
        tv[1] = '{1, 9'b000000000, 4'd9,  1'b0, 1'b0, 731, 28, 676};
        tv[2] = '{0, 9'b101010101, 4'd5,  1'b1, 1'b0, 0,   28, 676};
        tv[3] = '{0, 9'b101010101, 4'd5,  1'b0, 1'b1, 731, 28, 676};
        tv[4] = '{0, 9'b101010101, 4'd0,  1'b0, 1'b0, 731, 28, 676};
        tv[5] = '{0, 9'b101010101, 4'd10, 1'b0, 1'b0, 731, 28, 676};
        tv[6] = '{2, 9'h1B3,       4'd4,  1'b1, 1'b0, 0,   28, 676};
        tv[7] = '{2, 9'h0F0,       4'd6,  1'b0, 1'b0, 731, 28, 676};

        #2;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_valid", 32'(bus.o_valid), 0);
        chk("rst_rd_en", 32'(bus.rd_en), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_outs", 32'({bus.o_row, bus.o_col, bus.o_popcnt}), 0);
        #20 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_frame(tv[i]);

        prep(tv[0]);
        wait_c = 0;
        do begin
            @(negedge clk);
            wait_c++;
        end while (!(bus.o_valid && bus.o_row == 5'd10 && bus.o_col == 5'd7)
                   && wait_c < 2000);
        chk("reach_10_7", 32'(bus.o_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.o_valid), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_rd_en", 32'(bus.rd_en), 0);
        chk("arst_popcnt", 32'(bus.o_popcnt), 0);
        chk("arst_done", 32'(bus.done), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(tv[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
